// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, branch-on-load and mult/div busy
// hazards. It drives the PC and IF/ID write enables, the ID/EX bubble, the IF/ID flush and md_start.
module hazard_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       id_branch,
    input  logic       id_taken,
    input  logic       id_md_op,
    input  logic       id_md_read,
    input  logic       ex_memread,
    input  logic       ex_regwrite,
    input  logic [4:0] ex_dst,
    input  logic       mem_memread,
    input  logic [4:0] mem_dst,
    output logic       pc_write,
    output logic       ifid_write,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       md_start,
    output logic       md_busy,
    output logic [1:0] stall_cause,
    output logic       dbgState
);

    typedef enum logic {RUN = 1'b0, BSTALL = 1'b1} stateT;

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT);

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] mdCnt;

    logic exMatch;
    logic memMatch;
    logic loadUse;
    logic branchLoad2;
    logic branchLoad1;
    logic mdHazard;
    logic inBStall;
    logic stall;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    assign exMatch  = (ex_dst != 5'd0) &&
                      ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    assign memMatch = (mem_dst != 5'd0) &&
                      ((mem_dst == id_rs) || (id_uses_rt && (mem_dst == id_rt)));

    assign loadUse     = ex_memread & exMatch & ~id_branch;
    assign branchLoad2 = id_branch & ex_memread & exMatch;
    assign branchLoad1 = id_branch & mem_memread & memMatch;
    assign md_busy     = (mdCnt != '0);
    assign mdHazard    = (id_md_op | id_md_read) & md_busy;
    assign inBStall    = (state == BSTALL);
    assign stall       = loadUse | branchLoad1 | branchLoad2 | mdHazard | inBStall;
    assign dbgState    = state;

    // A non-load EX writer feeding an ID branch is covered by the EX->ID forward path,
    // so ex_regwrite only qualifies forwarding elsewhere and never stalls here.
    logic unusedRegwrite;
    assign unusedRegwrite = ex_regwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext   = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        md_start    = 1'b0;
        stall_cause = 2'b00;

        case (state)
            RUN:     if (branchLoad2 && !mdHazard) stateNext = BSTALL;
            BSTALL:  stateNext = RUN;
            default: stateNext = RUN;
        endcase

        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = id_taken;
            md_start   = id_md_op;
        end

        // In BSTALL the load has moved to MEM, so branchLoad1 marks the same stall.
        if (mdHazard) begin
            stall_cause = 2'b11;
        end else if (branchLoad1 || branchLoad2 || inBStall) begin
            stall_cause = 2'b10;
        end else if (loadUse) begin
            stall_cause = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdCnt <= '0;
        end else if (md_start) begin
            mdCnt <= MD_LOAD;
        end else if (mdCnt != '0) begin
            mdCnt <= mdCnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: each step drives ID/EX/MEM context, queues the
// expected control vector and compares it against the DUT away from the clock edge.
module tb_hazard_stall_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_branch;
    logic       id_taken;
    logic       id_md_op;
    logic       id_md_read;
    logic       ex_memread;
    logic       ex_regwrite;
    logic [4:0] ex_dst;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       pc_write;
    logic       ifid_write;
    logic       idex_bubble;
    logic       ifid_flush;
    logic       md_start;
    logic       md_busy;
    logic [1:0] stall_cause;
    logic       dbgState;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    // {pc_write, ifid_write, idex_bubble, ifid_flush, md_start, md_busy, stall_cause, state}
    localparam logic [8:0] IDLE     = 9'b11_0_0_0_0_00_0;
    localparam logic [8:0] LU       = 9'b00_1_0_0_0_01_0;
    localparam logic [8:0] BR_RUN   = 9'b00_1_0_0_0_10_0;
    localparam logic [8:0] BR_BST   = 9'b00_1_0_0_0_10_1;
    localparam logic [8:0] FLUSH    = 9'b11_0_1_0_0_00_0;
    localparam logic [8:0] START    = 9'b11_0_0_1_0_00_0;
    localparam logic [8:0] MD_STALL = 9'b00_1_0_0_1_11_0;
    localparam logic [8:0] BUSY     = 9'b11_0_0_0_1_00_0;
    localparam logic [8:0] BR_RUN_B = 9'b00_1_0_0_1_10_0;
    localparam logic [8:0] BR_BST_B = 9'b00_1_0_0_1_10_1;

    hazard_stall_ctrl #(.MD_LAT(4), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .id_branch   (id_branch),
        .id_taken    (id_taken),
        .id_md_op    (id_md_op),
        .id_md_read  (id_md_read),
        .ex_memread  (ex_memread),
        .ex_regwrite (ex_regwrite),
        .ex_dst      (ex_dst),
        .mem_memread (mem_memread),
        .mem_dst     (mem_dst),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .idex_bubble (idex_bubble),
        .ifid_flush  (ifid_flush),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .stall_cause (stall_cause),
        .dbgState    (dbgState)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    // Driver and scoreboard tasks
    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_branch = 1'b0;
        id_taken = 1'b0; id_md_op = 1'b0; id_md_read = 1'b0;
        ex_memread = 1'b0; ex_regwrite = 1'b0; ex_dst = 5'd0;
        mem_memread = 1'b0; mem_dst = 5'd0;
    endtask

    task automatic compareNow(input string tag);
        logic [8:0] obs;
        logic [8:0] expv;
        obs  = {pc_write, ifid_write, idex_bubble, ifid_flush, md_start, md_busy,
                stall_cause, dbgState};
        expv = exp_q.pop_front();
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic checkNow(input string tag, input logic [8:0] expv);
        exp_q.push_back(expv);
        compareNow(tag);
    endtask

    // Queue the expectation, compare mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input logic [8:0] expv);
        exp_q.push_back(expv);
        @(negedge clk);
        compareNow(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        step("reset_state", IDLE);
        rst_n = 1'b1;
        step("idle_after_reset", IDLE);

        // Load-use on rs; a taken branch/jump is held off while stalled
        ex_memread = 1'b1; ex_dst = 5'd5; id_rs = 5'd5; id_taken = 1'b1;
        step("lu_rs", LU);
        clr(); mem_memread = 1'b1; mem_dst = 5'd5; id_rs = 5'd5;
        step("lu_released", IDLE);
        clr(); ex_memread = 1'b1; ex_dst = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        step("lu_rt", LU);
        id_uses_rt = 1'b0;
        step("lu_rt_unused", IDLE);
        clr(); ex_memread = 1'b1; ex_dst = 5'd0; id_rs = 5'd0;
        step("lu_r0", IDLE);

        // Branch depending on a load in EX: two stall cycles through BSTALL
        clr(); id_branch = 1'b1; id_rs = 5'd3; ex_memread = 1'b1; ex_dst = 5'd3;
        step("bl2_first", BR_RUN);
        ex_memread = 1'b0; mem_memread = 1'b1; mem_dst = 5'd3;
        step("bl2_bstall", BR_BST);
        mem_memread = 1'b0; id_taken = 1'b1;
        step("bl2_release_flush", FLUSH);

        // Branch depending on a load in MEM: one stall cycle, FSM stays in RUN
        clr(); id_branch = 1'b1; id_rt = 5'd6; id_uses_rt = 1'b1;
        mem_memread = 1'b1; mem_dst = 5'd6;
        step("bl1", BR_RUN);
        clr();
        step("bl1_released", IDLE);

        // ALU result in EX feeding a branch is forwarded: no stall
        id_branch = 1'b1; id_taken = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd4;
        ex_regwrite = 1'b1; ex_dst = 5'd4;
        step("bal_flush", FLUSH);

        // mult then mflo waits out the four busy cycles
        clr(); id_md_op = 1'b1;
        step("md_start", START);
        clr(); id_md_read = 1'b1;
        for (int i = 0; i < 4; i++) step($sformatf("mflo_wait_%0d", i), MD_STALL);
        step("mflo_issue", IDLE);

        // Back-to-back mult: second one issues the cycle after the count reaches 1
        clr(); id_md_op = 1'b1;
        step("md_start_a", START);
        for (int i = 0; i < 4; i++) step($sformatf("mult_wait_%0d", i), MD_STALL);
        step("md_start_b", START);

        // Priority: mult/div busy outranks branch-on-load and load-use
        clr(); id_md_read = 1'b1; id_branch = 1'b1; id_rs = 5'd3;
        ex_memread = 1'b1; ex_dst = 5'd3;
        step("prio_md_over_bl2", MD_STALL);
        clr(); id_md_read = 1'b1; id_rs = 5'd5; ex_memread = 1'b1; ex_dst = 5'd5;
        step("prio_md_over_lu", MD_STALL);
        clr();
        step("busy_no_md_op_2", BUSY);
        step("busy_no_md_op_1", BUSY);
        step("busy_done", IDLE);

        // Asynchronous reset while in BSTALL with the mult/div counter at 3
        id_md_op = 1'b1;
        step("md_start_c", START);
        clr(); id_branch = 1'b1; id_rs = 5'd3; ex_memread = 1'b1; ex_dst = 5'd3;
        step("bl2_while_busy", BR_RUN_B);
        clr();
        checkNow("bstall_pre_reset", BR_BST_B);
        #1 rst_n = 1'b0;
        #1 checkNow("async_reset", IDLE);
        step("reset_held", IDLE);
        rst_n = 1'b1;
        step("after_reset", IDLE);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
